axi_lite_ram_slave: RTL and testbench

AXI4-Lite responder fronting a word-addressed, byte-writable on-chip RAM. It is the target end of the bus the core's memory stage drives for loads and stores. It accepts one read or one write at a time, performs the RAM access, and returns an R or B response with OKAY/SLVERR. Partially captured writes and reads presented in the same cycle are buffered and served in a fixed order.

---
 rtl/axi_pkg.sv | 6 +
 rtl/bram_be.sv | 20 ++
 rtl/axi_lite_ram_slave.sv | 159 +++++++++++++++
 tb/tb_axi_lite_ram_slave.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// axi_pkg: response codes and controller state encoding shared by the AXI-Lite RAM slave
package axi_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [2:0] {IDLE, RD, RRESP, WR, BRESP} state_e;
endpackage

// File: rtl/bram_be.sv
// bram_be: single-port synchronous RAM with byte enables and one-cycle read latency
module bram_be #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++)
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      rdata <= mem[addr];
    end
  end
endmodule

// File: rtl/axi_lite_ram_slave.sv
// axi_lite_ram_slave: AXI4-Lite responder serving one read or write at a time from a byte-writable RAM
module axi_lite_ram_slave
  import axi_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] axi_araddr,
  input  logic        axi_arvalid,
  output logic        axi_arready,
  input  logic [2:0]  axi_arprot,
  output logic [31:0] axi_rdata,
  output logic [1:0]  axi_rresp,
  output logic        axi_rvalid,
  input  logic        axi_rready,
  input  logic [31:0] axi_awaddr,
  input  logic        axi_awvalid,
  output logic        axi_awready,
  input  logic [2:0]  axi_awprot,
  input  logic [31:0] axi_wdata,
  input  logic [3:0]  axi_wstrb,
  input  logic        axi_wvalid,
  output logic        axi_wready,
  output logic [1:0]  axi_bresp,
  output logic        axi_bvalid,
  input  logic        axi_bready
);
  localparam logic [32:0] SPAN = 33'd4 << DEPTH_LOG2;
  state_e state_q, state_d;
  logic ar_cap_q, ar_cap_d, aw_cap_q, aw_cap_d, w_cap_q, w_cap_d;
  logic [31:0] araddr_q, araddr_d, awaddr_q, awaddr_d, wdata_q, wdata_d;
  logic [3:0] wstrb_q, wstrb_d;
  logic arready_q, arready_d, awready_q, awready_d, wready_q, wready_d;
  logic rvalid_q, rvalid_d, bvalid_q, bvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0] rresp_q, rresp_d, bresp_q, bresp_d;
  logic ram_en;
  logic [3:0] ram_we;
  logic [DEPTH_LOG2-1:0] ram_addr;
  logic [31:0] ram_rdata, rd_addr, rd_off, aw_off;
  logic rd_ok, aw_ok, ar_hs, aw_hs, w_hs;
  logic unused_prot;
  assign unused_prot = ^{axi_arprot, axi_awprot};
  // The RAM read is launched in the AR handshake cycle so registered rdata lands two cycles later
  assign rd_addr = ar_cap_q ? araddr_q : axi_araddr;
  assign rd_off  = rd_addr - BASE_ADDR;
  assign aw_off  = awaddr_q - BASE_ADDR;
  assign rd_ok   = {1'b0, rd_off} < SPAN;
  assign aw_ok   = {1'b0, aw_off} < SPAN;
  assign ar_hs   = axi_arvalid && arready_q;
  assign aw_hs   = axi_awvalid && awready_q;
  assign w_hs    = axi_wvalid && wready_q;
  always_comb begin
    state_d  = state_q;
    ar_cap_d = ar_cap_q | ar_hs;
    aw_cap_d = aw_cap_q | aw_hs;
    w_cap_d  = w_cap_q | w_hs;
    araddr_d = ar_hs ? axi_araddr : araddr_q;
    awaddr_d = aw_hs ? axi_awaddr : awaddr_q;
    wdata_d  = w_hs ? axi_wdata : wdata_q;
    wstrb_d  = w_hs ? axi_wstrb : wstrb_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    ram_en   = 1'b0;
    ram_we   = 4'b0000;
    ram_addr = rd_off[DEPTH_LOG2+1:2];
    case (state_q)
      IDLE: begin
        state_d = ar_cap_d ? RD : (aw_cap_d && w_cap_d) ? WR : IDLE;
        ram_en  = ar_cap_d && rd_ok;
      end
      RD: begin
        state_d  = RRESP;
        ar_cap_d = 1'b0;
        rvalid_d = 1'b1;
        rdata_d  = rd_ok ? ram_rdata : 32'h0;
        rresp_d  = rd_ok ? RESP_OKAY : RESP_SLVERR;
      end
      RRESP: if (axi_rready) begin
        rvalid_d = 1'b0;
        state_d  = (aw_cap_q && w_cap_q) ? WR : IDLE;
      end
      WR: begin
        state_d  = BRESP;
        aw_cap_d = 1'b0;
        w_cap_d  = 1'b0;
        ram_en   = aw_ok;
        ram_we   = aw_ok ? wstrb_q : 4'b0000;
        ram_addr = aw_off[DEPTH_LOG2+1:2];
        bvalid_d = 1'b1;
        bresp_d  = aw_ok ? RESP_OKAY : RESP_SLVERR;
      end
      BRESP: if (axi_bready) begin
        bvalid_d = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    arready_d = (state_d == IDLE) && !ar_cap_d;
    awready_d = (state_d == IDLE) && !aw_cap_d;
    wready_d  = (state_d == IDLE) && !w_cap_d;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      ar_cap_q  <= 1'b0;
      aw_cap_q  <= 1'b0;
      w_cap_q   <= 1'b0;
      arready_q <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      rdata_q   <= 32'h0;
      rresp_q   <= RESP_OKAY;
      bresp_q   <= RESP_OKAY;
    end else begin
      state_q   <= state_d;
      ar_cap_q  <= ar_cap_d;
      aw_cap_q  <= aw_cap_d;
      w_cap_q   <= w_cap_d;
      arready_q <= arready_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      rvalid_q  <= rvalid_d;
      bvalid_q  <= bvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      bresp_q   <= bresp_d;
    end
  end
  always_ff @(posedge clk) begin
    araddr_q <= araddr_d;
    awaddr_q <= awaddr_d;
    wdata_q  <= wdata_d;
    wstrb_q  <= wstrb_d;
  end
  bram_be #(.AW(DEPTH_LOG2)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );
  assign axi_arready = arready_q;
  assign axi_awready = awready_q;
  assign axi_wready  = wready_q;
  assign axi_rvalid  = rvalid_q;
  assign axi_rdata   = rdata_q;
  assign axi_rresp   = rresp_q;
  assign axi_bvalid  = bvalid_q;
  assign axi_bresp   = bresp_q;
endmodule

// File: tb/tb_axi_lite_ram_slave.sv
// tb_axi_lite_ram_slave: directed scoreboard bench for the AXI-Lite RAM slave
module tb_axi_lite_ram_slave;
  logic clk = 1'b0, rstn = 1'b0;
  logic [31:0] axi_araddr = '0, axi_awaddr = '0, axi_wdata = '0;
  logic axi_arvalid = 1'b0, axi_awvalid = 1'b0, axi_wvalid = 1'b0;
  logic axi_rready = 1'b0, axi_bready = 1'b0;
  logic [3:0] axi_wstrb = '0;
  logic axi_arready, axi_awready, axi_wready, axi_rvalid, axi_bvalid;
  logic [31:0] axi_rdata;
  logic [1:0] axi_rresp, axi_bresp;
  int cyc = 0, total = 0, bad = 0;
  typedef struct {logic [31:0] data; logic [1:0] resp;} rd_t;
  rd_t rexp[$];
  logic [1:0] bexp[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  axi_lite_ram_slave dut (
    .clk(clk), .rstn(rstn),
    .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_arprot(3'b000),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awprot(3'b000),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic to_fail(input string tag);
    total++;
    bad++;
    $error("FAIL %s: bound expired", tag);
  endtask
  task automatic ar_go(input logic [31:0] a, output int c);
    c = -1;
    axi_araddr = a;
    axi_arvalid = 1'b1;
    for (int i = 0; i < 20 && c < 0; i++) begin
      if (axi_arready) c = cyc;
      step();
    end
    axi_arvalid = 1'b0;
    if (c < 0) to_fail("ar_handshake");
  endtask
  task automatic wr_go(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int lead, output int c);
    int ca = -1, cw = -1;
    axi_awaddr = a;
    axi_wdata = d;
    axi_wstrb = s;
    axi_wvalid = 1'b1;
    axi_awvalid = (lead == 0);
    for (int i = 0; i < 30 && (ca < 0 || cw < 0); i++) begin
      if (axi_awvalid && axi_awready) ca = cyc;
      if (axi_wvalid && axi_wready) cw = cyc;
      step();
      if (ca >= 0) axi_awvalid = 1'b0;
      else if (i + 1 >= lead) axi_awvalid = 1'b1;
      if (cw >= 0) axi_wvalid = 1'b0;
      if (lead > 0 && cw >= 0 && ca < 0) begin
        chk("w_first_wready", axi_wready, 0);
        chk("w_first_awready", axi_awready, 1);
      end
    end
    axi_awvalid = 1'b0;
    axi_wvalid = 1'b0;
    c = (ca > cw) ? ca : cw;
    if (ca < 0 || cw < 0) to_fail("aw_w_handshake");
  endtask
  task automatic wait_r(input int exp_c, input int hold, input bit b2b);
    rd_t e;
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (axi_rvalid) begin
        seen = 1'b1;
        e = (rexp.size() != 0) ? rexp.pop_front() : '{32'hx, 2'bx};
        if (exp_c >= 0) chk("r_latency", cyc, exp_c);
        chk("r_before_b", axi_bvalid, 0);
        chk("rdata", axi_rdata, e.data);
        chk("rresp", axi_rresp, e.resp);
        for (int k = 0; k < hold; k++) begin
          chk("r_hold_readies", {axi_arready, axi_awready, axi_wready}, 0);
          step();
          chk("r_hold_rvalid", axi_rvalid, 1);
          chk("r_hold_rdata", axi_rdata, e.data);
          chk("r_hold_rresp", axi_rresp, e.resp);
        end
        axi_rready = 1'b1;
        step();
        axi_rready = 1'b0;
        chk("r_drop", axi_rvalid, 0);
        if (b2b) chk("r_b2b_readies", {axi_arready, axi_awready, axi_wready}, 3'b111);
      end else step();
    end
    if (!seen) to_fail("r_wait");
  endtask
  task automatic wait_b(input int exp_c);
    logic [1:0] e;
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (axi_bvalid) begin
        seen = 1'b1;
        e = (bexp.size() != 0) ? bexp.pop_front() : 2'bx;
        if (exp_c >= 0) chk("b_latency", cyc, exp_c);
        chk("bresp", axi_bresp, e);
        axi_bready = 1'b1;
        step();
        axi_bready = 1'b0;
        chk("b_drop", axi_bvalid, 0);
        chk("b_b2b_readies", {axi_arready, axi_awready, axi_wready}, 3'b111);
      end else step();
    end
    if (!seen) to_fail("b_wait");
  endtask
  task automatic rd(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
    int c;
    rexp.push_back('{d, r});
    ar_go(a, c);
    wait_r(c + 2, 0, 1'b1);
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] r);
    int c;
    bexp.push_back(r);
    wr_go(a, d, s, 0, c);
    wait_b(c + 2);
  endtask
  initial begin
    int c;
    bit seen;
    step();
    step();
    chk("rst_readies", {axi_arready, axi_awready, axi_wready}, 0);
    chk("rst_rvalid", axi_rvalid, 0);
    chk("rst_bvalid", axi_bvalid, 0);
    chk("rst_rdata", axi_rdata, 0);
    chk("rst_rresp", axi_rresp, 0);
    chk("rst_bresp", axi_bresp, 0);
    rstn = 1'b1;
    step();
    chk("post_rst_readies", {axi_arready, axi_awready, axi_wready}, 3'b111);
    wr(32'h10, 32'hDEADBEEF, 4'hF, 2'b00);
    rd(32'h10, 32'hDEADBEEF, 2'b00);
    wr(32'h12, 32'h0000AB00, 4'b0010, 2'b00);
    rd(32'h10, 32'hDEADABEF, 2'b00);
    bexp.push_back(2'b00);
    wr_go(32'h20, 32'hCAFEF00D, 4'hF, 3, c);
    wait_b(c + 2);
    rd(32'h20, 32'hCAFEF00D, 2'b00);
    rexp.push_back('{32'hDEADABEF, 2'b00});
    bexp.push_back(2'b00);
    axi_araddr = 32'h10;
    axi_awaddr = 32'h10;
    axi_wdata = 32'h12345678;
    axi_wstrb = 4'hF;
    axi_arvalid = 1'b1;
    axi_awvalid = 1'b1;
    axi_wvalid = 1'b1;
    chk("same_cycle_readies", {axi_arready, axi_awready, axi_wready}, 3'b111);
    c = cyc;
    step();
    axi_arvalid = 1'b0;
    axi_awvalid = 1'b0;
    axi_wvalid = 1'b0;
    chk("same_cycle_busy", {axi_arready, axi_awready, axi_wready}, 0);
    wait_r(c + 2, 0, 1'b0);
    wait_b(-1);
    rd(32'h10, 32'h12345678, 2'b00);
    wr(32'h20, 32'h0, 4'b0000, 2'b00);
    rd(32'h20, 32'hCAFEF00D, 2'b00);
    rexp.push_back('{32'h12345678, 2'b00});
    ar_go(32'h10, c);
    wait_r(c + 2, 5, 1'b1);
    wr(32'h0, 32'h11111111, 4'hF, 2'b00);
    wr(32'h4000, 32'hFFFFFFFF, 4'hF, 2'b10);
    rd(32'h4000, 32'h0, 2'b10);
    rd(32'h0, 32'h11111111, 2'b00);
    rd(32'h10, 32'h12345678, 2'b00);
    ar_go(32'h10, c);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (axi_rvalid) seen = 1'b1;
      else step();
    end
    if (!seen) to_fail("rrst_wait");
    chk("rrst_rdata", axi_rdata, 32'h12345678);
    rstn = 1'b0;
    step();
    chk("rrst_rvalid", axi_rvalid, 0);
    chk("rrst_readies", {axi_arready, axi_awready, axi_wready}, 0);
    rstn = 1'b1;
    step();
    chk("rrst_release_readies", {axi_arready, axi_awready, axi_wready}, 3'b111);
    rd(32'h10, 32'h12345678, 2'b00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
